wb_byte_arb: RTL

Round-robin Wishbone arbiter sharing one 8-bit byte-register slave (single-register store, one-cycle ack, read data valid one cycle after ack) among NMST masters. Sits between CPU/peripheral masters and the byte slave. Sequences each transfer through a fixed state machine and hides the slave's late read data behind a registered response. Guards against a dead slave with an ack timeout.

---
 rtl/wb_byte_pkg.sv | 13 +
 rtl/wb_rr_pick.sv | 38 +++
 rtl/wb_byte_arb.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_byte_pkg.sv
// Shared definitions for the round-robin Wishbone byte-register arbiter.
package wb_byte_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } wb_state_t;

    localparam int WB_DSIZE = 8;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last,
// wrapping circularly.
module wb_rr_pick #(
    parameter int NMST = 4,
    parameter int IW   = (NMST > 1) ? $clog2(NMST) : 1
) (
    input  logic [NMST-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_grant,
    output logic            o_valid
);

    localparam logic [IW:0] NM = (IW+1)'(NMST);

    logic [IW-1:0] w_idx [NMST];
    logic [NMST-1:0] w_hit;

    // Slot gi holds the master index at circular distance gi+1 from i_last.
    generate
        for (genvar gi = 0; gi < NMST; gi++) begin : g_rot
            logic [IW:0] w_sum;
            assign w_sum     = {1'b0, i_last} + (IW+1)'(gi + 1);
            assign w_idx[gi] = (w_sum >= NM) ? IW'(w_sum - NM) : IW'(w_sum);
            assign w_hit[gi] = i_req[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        o_grant = '0;
        o_valid = |w_hit;
        for (int k = NMST - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_grant = w_idx[k];
            end
        end
    end

endmodule

// File: rtl/wb_byte_arb.sv
// Round-robin arbiter sharing one byte-register Wishbone slave among NMST
// masters, with registered response and an ack timeout.
module wb_byte_arb
    import wb_byte_pkg::*;
#(
    parameter int NMST  = 4,
    parameter int DSIZE = WB_DSIZE,
    parameter int TMO   = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NMST-1:0]       i_m_stb,
    input  logic [NMST-1:0]       i_m_we,
    input  logic [NMST*DSIZE-1:0] i_m_dat,
    output logic [NMST-1:0]       o_m_ack,
    output logic [NMST-1:0]       o_m_err,
    output logic [NMST*DSIZE-1:0] o_m_dat,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [DSIZE-1:0]      o_s_dat,
    input  logic                  i_s_ack,
    input  logic [DSIZE-1:0]      i_s_dat
);

    localparam int IW = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int CW = $clog2(TMO + 1);

    wb_state_t             r_state, w_state_next;
    logic [IW-1:0]         r_grant, w_grant_next;
    logic [IW-1:0]         r_last, w_last_next;
    logic                  r_we, w_we_next;
    logic [DSIZE-1:0]      r_wdat, w_wdat_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic                  r_s_stb, w_s_stb_next;
    logic [NMST-1:0]       r_m_ack, w_m_ack_next;
    logic [NMST-1:0]       r_m_err, w_m_err_next;
    logic [NMST*DSIZE-1:0] r_m_dat, w_m_dat_next;

    logic [IW-1:0]         w_pick_grant;
    logic                  w_pick_valid;

    wb_rr_pick #(
        .NMST (NMST),
        .IW   (IW)
    ) u_pick (
        .i_req   (i_m_stb),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IW'(NMST - 1);
            r_we    <= 1'b0;
            r_wdat  <= '0;
            r_cnt   <= '0;
            r_s_stb <= 1'b0;
            r_m_ack <= '0;
            r_m_err <= '0;
            r_m_dat <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_we    <= w_we_next;
            r_wdat  <= w_wdat_next;
            r_cnt   <= w_cnt_next;
            r_s_stb <= w_s_stb_next;
            r_m_ack <= w_m_ack_next;
            r_m_err <= w_m_err_next;
            r_m_dat <= w_m_dat_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_we_next    = r_we;
        w_wdat_next  = r_wdat;
        w_cnt_next   = r_cnt;
        w_s_stb_next = r_s_stb;
        w_m_ack_next = '0;
        w_m_err_next = '0;
        w_m_dat_next = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_next = w_pick_grant;
                    w_we_next    = i_m_we[w_pick_grant];
                    w_wdat_next  = i_m_dat[w_pick_grant*DSIZE +: DSIZE];
                    w_cnt_next   = '0;
                    w_s_stb_next = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                // The strobe drops one cycle before the counter hits TMO so it
                // is high for exactly TMO cycles on a dead slave.
                if (r_cnt == CW'(TMO)) begin
                    w_s_stb_next          = 1'b0;
                    w_m_err_next[r_grant] = 1'b1;
                    w_state_next          = ST_RESP;
                end else if (i_s_ack) begin
                    w_s_stb_next = 1'b0;
                    w_state_next = ST_CAPT;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                    if ((r_cnt + CW'(1)) == CW'(TMO)) begin
                        w_s_stb_next = 1'b0;
                    end
                end
            end
            ST_CAPT: begin
                w_m_ack_next[r_grant] = 1'b1;
                if (!r_we) begin
                    w_m_dat_next[r_grant*DSIZE +: DSIZE] = i_s_dat;
                end
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_last_next  = r_grant;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_m_ack = r_m_ack;
    assign o_m_err = r_m_err;
    assign o_m_dat = r_m_dat;
    assign o_s_stb = r_s_stb;
    assign o_s_we  = r_we;
    assign o_s_dat = r_wdat;

endmodule
